// File: rtl/mem_arbiter.sv
// Arbiter sharing one synchronous-read memory between the CPU datapath and a DMA port.
// CPU has fixed priority; a saturating wait counter forces a DMA slot after MAXWAIT cycles.
module mem_arbiter #(
  parameter int unsigned MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_adr,
  input  logic [31:0] dma_wd,
  output logic [31:0] dma_rd,
  output logic        dma_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ISSUE,
    CPU_DONE,
    DMA_ISSUE,
    DMA_DONE
  } state_t;

  localparam logic [3:0] WMAX = 4'(MAXWAIT);

  state_t      state, state_nxt;
  logic [3:0]  wcnt;
  logic [31:0] cpu_hold, dma_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Wait counter holds during DMA_DONE; only DMA_ISSUE or a dropped request clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
    end else if (!dma_req || state == DMA_ISSUE) begin
      wcnt <= '0;
    end else if (state != DMA_DONE && wcnt < WMAX) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      if (state == CPU_DONE) cpu_hold <= mem_rd;
      if (state == DMA_DONE) dma_hold <= mem_rd;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wd    = '0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    cpu_rd    = cpu_hold;
    dma_rd    = dma_hold;
    case (state)
      IDLE: begin
        if (dma_req && (wcnt >= WMAX || !cpu_req)) state_nxt = DMA_ISSUE;
        else if (cpu_req)                          state_nxt = CPU_ISSUE;
      end
      CPU_ISSUE: begin
        state_nxt = CPU_DONE;
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_adr   = cpu_adr;
        mem_wd    = cpu_wd;
      end
      CPU_DONE: begin
        state_nxt = IDLE;
        cpu_ack   = 1'b1;
        cpu_rd    = mem_rd;
      end
      DMA_ISSUE: begin
        state_nxt = DMA_DONE;
        mem_en    = 1'b1;
        mem_we    = dma_we;
        mem_adr   = dma_adr;
        mem_wd    = dma_wd;
      end
      DMA_DONE: begin
        state_nxt = IDLE;
        dma_ack   = 1'b1;
        dma_rd    = mem_rd;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
